// File: rtl/mac_lane_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_lane_array_pkg
// Brief    : Shared types and helpers for the multi-lane MAC datapath.
// Revision : 1.0 - initial release
// ============================================================================

package mac_lane_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Scaling arithmetic is carried out at this width; accumulators up to
    // 63 bits keep one bit of headroom for the rounding addend.
    localparam int CALC_W = 64;

    function automatic int lane_idx_width(input int nb_lanes);
        return (nb_lanes > 1) ? $clog2(nb_lanes) : 1;
    endfunction

    localparam int DEFAULT_LANE_IDX_W = lane_idx_width(4);

    function automatic logic signed [CALC_W-1:0] sat_scale(
        input logic signed [CALC_W-1:0] val,
        input int                       shift,
        input int                       out_w,
        input bit                       round_en
    );
        logic signed [CALC_W-1:0] v;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        v = val;
        if (round_en && (shift > 0)) begin
            v = v + (64'sd1 <<< (shift - 1));
        end
        v  = v >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_lane_array_lane.sv
`default_nettype none
// ============================================================================
// Module   : mac_lane
// Brief    : One MAC lane: registered signed product feeding a wrapping
//            accumulator with synchronous initial-value load.
// Revision : 1.0 - initial release
// ============================================================================

module mac_lane #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 load_init,
    input  logic [ACC_WIDTH-1:0] init_val,
    input  logic                 prod_load,
    input  logic [A_WIDTH-1:0]   a_in,
    input  logic [B_WIDTH-1:0]   b_in,
    input  logic                 accumulate,
    output logic [ACC_WIDTH-1:0] acc
);

    logic [ACC_WIDTH-1:0]        prod_q;
    logic [ACC_WIDTH-1:0]        prod_d;
    logic [ACC_WIDTH-1:0]        acc_q;
    logic [ACC_WIDTH-1:0]        acc_d;
    logic signed [ACC_WIDTH-1:0] a_ext;
    logic signed [ACC_WIDTH-1:0] b_ext;

    always_comb begin
        a_ext  = ACC_WIDTH'($signed(a_in));
        b_ext  = ACC_WIDTH'($signed(b_in));
        prod_d = prod_q;
        if (prod_load) begin
            // ACC_WIDTH >= A_WIDTH+B_WIDTH, so the low bits hold the exact product
            prod_d = a_ext * b_ext;
        end
        acc_d = acc_q;
        if (load_init) begin
            acc_d = init_val;
        end else if (accumulate) begin
            acc_d = acc_q + prod_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/mac_lane_array.sv
`default_nettype none
// ============================================================================
// Module   : mac_lane_array
// Brief    : NB_LANES MAC lanes sharing a broadcast activation; results are
//            scaled, saturated and drained lane by lane on a valid/ready port.
//            Define MAC_LANE_ARRAY_ROUND_EN for round-half-up scaling.
// Revision : 1.0 - initial release
// ============================================================================

module mac_lane_array
    import mac_lane_array_pkg::*;
#(
    parameter int NB_LANES     = 4,
    parameter int A_WIDTH      = 16,
    parameter int B_WIDTH      = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int OUTPUT_SCALE = 0,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 arst_n_in,
    input  logic                                 start,
    input  logic [LEN_WIDTH-1:0]                 cfg_accum_len,
    input  logic                                 psum_use,
    input  logic [NB_LANES*ACC_WIDTH-1:0]        psum_in,
    output logic                                 busy,
    input  logic [A_WIDTH-1:0]                   a_input,
    input  logic                                 a_valid,
    output logic                                 a_ready,
    input  logic [NB_LANES*B_WIDTH-1:0]          b_input,
    input  logic                                 b_valid,
    output logic                                 b_ready,
    output logic [OUT_WIDTH-1:0]                 out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [lane_idx_width(NB_LANES)-1:0]  out_lane,
    output logic [ACC_WIDTH-1:0]                 out_acc
);

    localparam int c_lane_w = lane_idx_width(NB_LANES);
`ifdef MAC_LANE_ARRAY_ROUND_EN
    localparam bit c_round_en = 1'b1;
`else
    localparam bit c_round_en = 1'b0;
`endif

    state_t                 state_q;
    state_t                 state_d;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   len_d;
    logic [LEN_WIDTH-1:0]   count_q;
    logic [LEN_WIDTH-1:0]   count_d;
    logic [c_lane_w-1:0]    ptr_q;
    logic [c_lane_w-1:0]    ptr_d;
    logic                   prod_vld_q;
    logic                   prod_vld_d;

    logic                   start_fire;
    logic                   beat;
    logic                   last_beat;
    logic                   last_lane;
    logic [ACC_WIDTH-1:0]   lane_acc [NB_LANES];

    always_comb begin
        start_fire = (state_q == IDLE) && start;
        beat       = (state_q == ACCUM) && a_valid && b_valid;
        last_beat  = beat && (count_q == (len_q - LEN_WIDTH'(1)));
        last_lane  = (ptr_q == c_lane_w'(NB_LANES - 1));
    end

    genvar g;
    generate
        for (g = 0; g < NB_LANES; g++) begin : g_lane
            mac_lane #(
                .A_WIDTH   (A_WIDTH),
                .B_WIDTH   (B_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_lane (
                .clk        (clk),
                .arst_n_in  (arst_n_in),
                .load_init  (start_fire),
                .init_val   (psum_use ? psum_in[g*ACC_WIDTH +: ACC_WIDTH] : '0),
                .prod_load  (beat),
                .a_in       (a_input),
                .b_in       (b_input[g*B_WIDTH +: B_WIDTH]),
                .accumulate (prod_vld_q),
                .acc        (lane_acc[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            len_q      <= '0;
            count_q    <= '0;
            ptr_q      <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            prod_vld_q <= prod_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_accum_len != '0) ? ACCUM : FLUSH;
                end
            end
            ACCUM: begin
                if (last_beat) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (out_ready && last_lane) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, latched length and the product-valid pipeline bit
    always_comb begin
        len_d      = len_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        prod_vld_d = beat;
        if (start_fire) begin
            len_d   = cfg_accum_len;
            count_d = '0;
        end else if (beat) begin
            count_d = count_q + LEN_WIDTH'(1);
        end
        if (state_q == FLUSH) begin
            ptr_d = '0;
        end else if ((state_q == DRAIN) && out_ready) begin
            ptr_d = last_lane ? '0 : ptr_q + c_lane_w'(1);
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        a_ready   = (state_q == ACCUM);
        b_ready   = (state_q == ACCUM);
        out_valid = (state_q == DRAIN);
        out_lane  = ptr_q;
        out_acc   = lane_acc[ptr_q];
        out       = OUT_WIDTH'(sat_scale(CALC_W'($signed(lane_acc[ptr_q])),
                                         OUTPUT_SCALE, OUT_WIDTH, c_round_en));
    end

endmodule

`default_nettype wire

// File: doc/mac_lane_array.md
Name: mac_lane_array

Overview:
- Parametrised successor to the single-MAC datapath: NB_LANES MAC lanes share one broadcast activation; each lane has its own weight.
- Each lane accumulates cfg_accum_len products on top of an optional initial partial sum.
- Results are scaled, saturated and serialised lane by lane on a valid/ready output port.
- Sits between the controller/input streams and the external partial-sum memory / output port of the chip top.

Parameters:
- NB_LANES, 4, number of parallel MAC lanes (>=1)
- A_WIDTH, 16, signed activation width
- B_WIDTH, 16, signed weight width per lane
- ACC_WIDTH, 32, signed accumulator and partial-sum width (>= A_WIDTH+B_WIDTH)
- OUT_WIDTH, 16, signed output width
- OUTPUT_SCALE, 0, arithmetic right shift applied before saturation (0..ACC_WIDTH-OUT_WIDTH)
- LEN_WIDTH, 16, width of cfg_accum_len

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- start  in  1  begin a job; sampled only in IDLE
- cfg_accum_len  in  LEN_WIDTH  products per lane; sampled with start
- psum_use  in  1  1: initialise accumulators from psum_in; 0: from zero; sampled with start
- psum_in  in  NB_LANES*ACC_WIDTH  initial partial sums; lane i at bits [i*ACC_WIDTH +: ACC_WIDTH]
- busy  out  1  high in every state except IDLE
- a_input  in  A_WIDTH  broadcast activation
- a_valid  in  1  activation valid
- a_ready  out  1  activation ready
- b_input  in  NB_LANES*B_WIDTH  per-lane weights, packed like psum_in
- b_valid  in  1  weight vector valid
- b_ready  out  1  weight vector ready
- out  out  OUT_WIDTH  scaled, saturated lane result
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_lane  out  $clog2(NB_LANES) (min 1)  lane index of out
- out_acc  out  ACC_WIDTH  unscaled accumulator of the current lane, for partial-sum write-back

Behaviour:
- Clocking and reset: single clock clk. arst_n_in is an asynchronous, active-low reset.
- Reset values: state IDLE; busy, a_ready, b_ready and out_valid 0; out, out_acc and out_lane 0; all accumulators, product registers and the beat counter 0.
- IDLE:
  - On start=1, latch cfg_accum_len as len and load accumulator i with psum_use ? psum_in[i] : 0.
  - Next state is ACCUM if len != 0, otherwise FLUSH.
- ACCUM:
  - a_ready = b_ready = 1. A beat is accepted only when a_valid && b_valid; there is no partial acceptance.
  - On each beat, product register i is loaded with signed a_input*b_input[i] (sign-extended to ACC_WIDTH), and prod_vld is set to 1 for one cycle.
  - One cycle later each accumulator adds its product. The sum wraps modulo 2^ACC_WIDTH; there is no overflow flag.
  - The beat counter increments per accepted beat. On the beat where count == len-1, the next state is FLUSH.
  - Stalls (valid low) insert no products.
- FLUSH:
  - Lasts one cycle, during which the last product is added. Ready signals are 0.
  - Next state is DRAIN with the lane pointer at 0.
- DRAIN:
  - out_valid = 1; out_lane = pointer; out_acc = acc[pointer].
  - out = sat_OUT_WIDTH(acc[pointer] >>> OUTPUT_SCALE).
  - On out_valid && out_ready the pointer increments. After lane NB_LANES-1 is accepted, the next state is IDLE and busy falls.
  - out, out_lane and out_acc hold stable while out_valid && !out_ready.
- Latency: the first out_valid is asserted 2 cycles after the clock edge that accepts the last beat. With len=0, out_valid is asserted 2 cycles after the start edge.
- Saturation: if the shifted value is > 2^(OUT_WIDTH-1)-1, out is clamped to that maximum; if it is < -2^(OUT_WIDTH-1), out is clamped to that minimum.
- Boundary conditions:
  - start outside IDLE is ignored.
  - cfg_accum_len, psum_use and psum_in are don't-care outside the start cycle.
  - Asserting reset mid-job aborts immediately to the reset state; partial results are discarded.
  - NB_LANES=1: out_lane is always 0.

Optional Feature:
- Macro: MAC_LANE_ARRAY_ROUND_EN.
- Defined: when OUTPUT_SCALE > 0, add 2^(OUTPUT_SCALE-1) to the accumulator before the shift (round half up), in ACC_WIDTH+1 bits so the addition cannot wrap, then saturate. out_acc is unaffected.
- Undefined: plain truncating arithmetic shift.

Decomposition:
- Package mac_lane_array_pkg:
  - state enum typedef {IDLE, ACCUM, FLUSH, DRAIN};
  - parametrised saturate/scale function;
  - localparam for the lane-index width.
- Sub-module mac_lane: one product register plus one accumulator, with load-init, product-valid and accumulate controls; instantiated NB_LANES times in a generate loop.
- The FSM, beat counter and drain mux live in mac_lane_array.

Test Plan:
- NB_LANES=4, len=3, psum_use=0, a={1,2,3}, b lane i = i+1 each beat, out_ready=1 -> outs 6,12,18,24 in lane order; first out_valid 2 cycles after the 3rd accept.
- psum_use=1, psum_in={100,-100,0,5}, len=1, a=2, b={1,1,1,1} -> 102,-98,2,7.
- len=2 with a_valid toggling 1,0,1 and b_valid lagging by one cycle -> exactly 2 products accumulated and results correct; stalls insert nothing.
- OUTPUT_SCALE=0, OUT_WIDTH=16, len=1, a=300, b=300 -> out=32767 and out_acc=90000; a=-300, b=300 -> out=-32768.
- out_ready held 0 for 5 cycles in DRAIN -> out/out_lane stable at lane 0, no lane skipped; a start pulse during DRAIN is ignored.
- Reset asserted mid-ACCUM -> all outputs 0 asynchronously; a new job after reset gives results with no residue. With the macro defined, OUTPUT_SCALE=2 and acc=6 -> out=2 (1 without the macro).
